fixture_probe_tx: RTL and testbench

FIXTURE_PROBE_TX -- requirements
Module: fixture_probe_tx

---
 rtl/fixture_probe_tx.sv | 203 ++++++++++++++++++++
 tb/tb_fixture_probe_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fixture_probe_tx.sv
// fixture_probe_tx: captures probe words into a small FIFO and serialises each
// one as a framed bit stream (start 0, WIDTH data bits LSB first, optional even
// parity, stop 1) under a per-bit ready handshake.
//
// Ports:
//   clock     - single clock, rising edge
//   reset_n   - asynchronous active-low reset
//   sample    - capture probe_in into the FIFO on this edge
//   probe_in  - WIDTH-bit word to capture
//   tx_ready  - sink accepts the current serial bit on this edge
//   tx_bit    - serial data, idles at 1
//   tx_valid  - tx_bit belongs to a frame
//   busy      - frame in progress or FIFO non-empty
//   level     - number of FIFO entries held
//   overflow  - sticky, set when a sample is dropped on a full FIFO
//
// Build option: define FIXTURE_PROBE_PARITY_EN to insert the even-parity bit
// (PAR state) between the data bits and the stop bit.

module fixture_probe_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       sample,
  input  logic [WIDTH-1:0]           probe_in,
  input  logic                       tx_ready,
  output logic                       tx_bit,
  output logic                       tx_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               tx_bit_q, tx_bit_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
`ifdef FIXTURE_PROBE_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               pop;
  logic               push;
  logic               advance;

  // A bit is consumed only while a frame is on the wire and the sink accepts it.
  assign advance = tx_valid_q & tx_ready;

  // Next-state, FIFO bookkeeping and next output values.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    pop        = 1'b0;
    push       = 1'b0;
    tx_bit_d   = 1'b1;
    tx_valid_d = 1'b0;
    busy_d     = 1'b0;
`ifdef FIXTURE_PROBE_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (advance) state_d = DATA;
      end
      DATA: begin
        if (advance) begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef FIXTURE_PROBE_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef FIXTURE_PROBE_PARITY_EN
      PAR: begin
        if (advance) state_d = STOP;
      end
`endif
      STOP: begin
        if (advance) begin
          // Chain straight into the next frame when data is waiting.
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      cnt_d    = '0;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef FIXTURE_PROBE_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
    end

    // A full FIFO still takes a sample when the head leaves on the same edge.
    push  = sample & ((level_q != LVL_W'(DEPTH)) | pop);
    ovf_d = ovf_q | (sample & ~push);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    // Outputs are registered from the next state so they line up with state_q.
    tx_valid_d = (state_d != IDLE);
    busy_d     = tx_valid_d | (level_d != '0);
    case (state_d)
      START:   tx_bit_d = 1'b0;
      DATA:    tx_bit_d = shift_d[0];
`ifdef FIXTURE_PROBE_PARITY_EN
      PAR:     tx_bit_d = par_d;
`endif
      default: tx_bit_d = 1'b1;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      tx_bit_q   <= 1'b1;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FIXTURE_PROBE_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
`ifdef FIXTURE_PROBE_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= probe_in;
  end

  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fixture_probe_tx.sv
// Directed bench for fixture_probe_tx (WIDTH=8, DEPTH=4). Frame length follows
// FIXTURE_PROBE_PARITY_EN so the same bench covers both builds.

module tb_fixture_probe_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
`ifdef FIXTURE_PROBE_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 3;
`else
  localparam int unsigned FRAME_LEN = WIDTH + 2;
`endif

  logic                       clock;
  logic                       reset_n;
  logic                       sample;
  logic [WIDTH-1:0]           probe_in;
  logic                       tx_ready;
  logic                       tx_bit;
  logic                       tx_valid;
  logic                       busy;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic                       overflow;

  int n_cmp = 0;
  int n_err = 0;

  fixture_probe_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .sample   (sample),
    .probe_in (probe_in),
    .tx_ready (tx_ready),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected serial bit idx of the frame carrying d.
  function automatic logic exp_bit(input logic [WIDTH-1:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= int'(WIDTH)) return d[idx-1];
`ifdef FIXTURE_PROBE_PARITY_EN
    if (idx == int'(WIDTH) + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic push_one(input logic [WIDTH-1:0] v);
    sample   = 1'b1;
    probe_in = v;
    step();
    sample   = 1'b0;
  endtask

  // Expects the start bit of a frame carrying d to be on the wire now; tx_ready=1.
  task automatic recv_frame(input logic [WIDTH-1:0] d, input bit do_push,
                            input logic [WIDTH-1:0] push_val);
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      check_eq($sformatf("valid %02h b%0d", d, i), 32'(tx_valid), 32'd1);
      check_eq($sformatf("bit %02h b%0d", d, i), 32'(tx_bit), 32'(exp_bit(d, i)));
      if (do_push && i == 2) begin
        sample   = 1'b1;
        probe_in = push_val;
      end
      step();
      sample = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " valid"}, 32'(tx_valid), 32'd0);
    check_eq({tag, " bit"},   32'(tx_bit),   32'd1);
    check_eq({tag, " busy"},  32'(busy),     32'd0);
    check_eq({tag, " level"}, 32'(level),    32'd0);
  endtask

  logic [WIDTH-1:0] ovals [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int               olvl  [6]  = '{1, 1, 2, 3, 4, 4};
  int               oovf  [6]  = '{0, 0, 0, 0, 0, 1};
  logic [WIDTH-1:0] wvals [10] = '{8'h01, 8'h80, 8'hFE, 8'h7F, 8'h55,
                                   8'hAA, 8'h0F, 8'hF0, 8'hC3, 8'h3C};

  initial begin
    reset_n  = 1'b1;
    sample   = 1'b0;
    probe_in = '0;
    tx_ready = 1'b1;

    // Asynchronous reset, observed before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check_idle("reset");
    check_eq("reset ovf", 32'(overflow), 32'd0);
    step();
    reset_n = 1'b1;

    // Single 0xA5 frame: latency, exact bit sequence, return to idle.
    push_one(8'hA5);
    check_eq("a5 lvl E0", 32'(level), 32'd1);
    check_eq("a5 valid E0", 32'(tx_valid), 32'd0);
    check_eq("a5 busy E0", 32'(busy), 32'd1);
    step();
    check_eq("a5 lvl E1", 32'(level), 32'd0);
    recv_frame(8'hA5, 1'b0, '0);
    check_idle("a5 end");

    // 0x07: odd popcount, parity bit 1 when enabled.
    push_one(8'h07);
    step();
    recv_frame(8'h07, 1'b0, '0);
    check_idle("07 end");

    // Six samples while stalled: fifth fills FIFO, sixth is dropped.
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample   = 1'b1;
      probe_in = ovals[k];
      step();
      check_eq($sformatf("ovf lvl s%0d", k), 32'(level), 32'(olvl[k]));
      check_eq($sformatf("ovf flag s%0d", k), 32'(overflow), 32'(oovf[k]));
    end
    sample = 1'b0;
    step();
    check_eq("ovf stall bit", 32'(tx_bit), 32'd0);
    check_eq("ovf stall lvl", 32'(level), 32'd4);
    tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) recv_frame(ovals[k], 1'b0, '0);
    check_idle("ovf end");
    check_eq("ovf sticky", 32'(overflow), 32'd1);

    // Stalls during DATA: ready pattern 1,0,0,1 holds each data bit 3 cycles.
    push_one(8'h3C);
    step();
    check_eq("stall start", 32'(tx_bit), 32'd0);
    step();
    for (int i = 1; i <= int'(WIDTH); i++) begin
      tx_ready = 1'b0;
      check_eq($sformatf("stall b%0d c0", i), 32'(tx_bit), 32'(exp_bit(8'h3C, i)));
      step();
      check_eq($sformatf("stall b%0d c1", i), 32'(tx_bit), 32'(exp_bit(8'h3C, i)));
      step();
      tx_ready = 1'b1;
      check_eq($sformatf("stall b%0d c2", i), 32'(tx_bit), 32'(exp_bit(8'h3C, i)));
      check_eq($sformatf("stall b%0d vld", i), 32'(tx_valid), 32'd1);
      step();
    end
    for (int i = int'(WIDTH) + 1; i < int'(FRAME_LEN); i++) begin
      check_eq($sformatf("stall tail b%0d", i), 32'(tx_bit), 32'(exp_bit(8'h3C, i)));
      step();
    end
    check_idle("stall end");

    // Reset during data bit 3 with one more word queued.
    push_one(8'hC3);
    push_one(8'h5A);
    step();
    step();
    step();
    step();
    check_eq("rst b3 bit", 32'(tx_bit), 32'd0);
    check_eq("rst b3 lvl", 32'(level), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle("rst async");
    check_eq("rst ovf", 32'(overflow), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check_eq($sformatf("rst post c%0d", i), 32'(tx_valid), 32'd0);
    end
    check_eq("rst post bit", 32'(tx_bit), 32'd1);

    // Ten contiguous frames with level kept at or below 2: pointers wrap.
    push_one(wvals[0]);
    push_one(wvals[1]);
    for (int k = 0; k < 10; k++) begin
      recv_frame(wvals[k], (k + 2) < 10, wvals[(k + 2) % 10]);
      check_eq($sformatf("wrap lvl f%0d", k), 32'(level), (k < 8) ? 32'd1 : 32'd0);
    end
    check_idle("wrap end");
    check_eq("wrap ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
